// File: rtl/alu_seq_if.sv
// ALU type package and command interface for the multiply/divide sequencer.
// Ports: master = control unit (start/cmd/operands), slave = alu_seq.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_NOP = 2'd0,
        ALU_ADD = 2'd1,
        ALU_SUB = 2'd2,
        ALU_THR = 2'd3
    } alu_op_e;

    // alu_carry: carry out for ADD, borrow for SUB, 0 for THR/NOP
    typedef struct packed {
        logic alu_carry;
        logic alu_zero;
    } alu_flag_t;

endpackage

interface alu_seq_if #(
    parameter int W = 8
);
    logic         start;
    logic         cmd;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result_hi;
    logic [W-1:0] result_lo;
    logic         result_zero;

    modport master (
        output start, cmd, operand_a, operand_b,
        input  busy, done, err, result_hi, result_lo, result_zero
    );

    modport slave (
        input  start, cmd, operand_a, operand_b,
        output busy, done, err, result_hi, result_lo, result_zero
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle MUL (shift-add) / DIV (restoring) sequencer driving a shared ALU.
// Ports: clk, rst_n (async low), bus (alu_seq_if.slave command/result side),
//   alu_op/alu_reg1/alu_reg2 to the ALU, alu_result/alu_flag from the ALU.
// Build option: define ALU_SEQ_DIV_EN to build the divider; otherwise
//   DIV commands finish in one clock with err=1 and a zero result.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_seq_if.slave                  bus,
    output alu_op_e                   alu_op,
    output logic [DATA_BUS_WIDTH-1:0] alu_reg1,
    output logic [DATA_BUS_WIDTH-1:0] alu_reg2,
    input  logic [DATA_BUS_WIDTH-1:0] alu_result,
    input  alu_flag_t                 alu_flag
);

    localparam int W  = DATA_BUS_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e        state;
    state_e        state_nx;
    logic [W-1:0]  acc;
    logic [W-1:0]  q;
    logic [W-1:0]  b;
    logic [CW-1:0] count;
    logic [W-1:0]  acc_nx;
    logic [W-1:0]  q_nx;
    logic [W-1:0]  res_hi;
    logic [W-1:0]  res_lo;
    logic          err_q;
    logic          zero_q;
    logic          last;

`ifdef ALU_SEQ_DIV_EN
    logic [W-1:0]  rem_shift;
    logic          ok;
`endif

    // The ALU zero flag is not needed by either algorithm.
    logic unused_flag;
    assign unused_flag = alu_flag.alu_zero;

    assign last = (count == CW'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, ALU drive and per-step datapath values
    always_comb begin
        state_nx = state;
        alu_op   = ALU_NOP;
        alu_reg1 = '0;
        alu_reg2 = '0;
        acc_nx   = acc;
        q_nx     = q;
`ifdef ALU_SEQ_DIV_EN
        rem_shift = {acc[W-2:0], q[W-1]};
        ok        = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (!bus.cmd) begin
                        state_nx = S_MUL;
                    end else begin
`ifdef ALU_SEQ_DIV_EN
                        state_nx = (bus.operand_b != '0) ? S_DIV : S_DONE;
`else
                        state_nx = S_DONE;
`endif
                    end
                end
            end
            S_MUL: begin
                // THR keeps ACC and reports carry 0, so one update
                // expression serves both the add and no-add steps.
                alu_op   = q[0] ? ALU_ADD : ALU_THR;
                alu_reg1 = acc;
                alu_reg2 = b;
                acc_nx   = {alu_flag.alu_carry, alu_result[W-1:1]};
                q_nx     = {alu_result[0], q[W-1:1]};
                if (last) begin
                    state_nx = S_DONE;
                end
            end
            S_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                // If the shifted-out bit was set the true remainder is
                // >= 2^W > B, so the subtract always succeeds and the
                // mod-2^W difference is exact.
                alu_op   = ALU_SUB;
                alu_reg1 = rem_shift;
                alu_reg2 = b;
                ok       = acc[W-1] | ~alu_flag.alu_carry;
                acc_nx   = ok ? alu_result : rem_shift;
                q_nx     = {q[W-2:0], ok};
                if (last) begin
                    state_nx = S_DONE;
                end
`else
                state_nx = S_IDLE;
`endif
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            q      <= '0;
            b      <= '0;
            count  <= '0;
            res_hi <= '0;
            res_lo <= '0;
            err_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc   <= '0;
                        q     <= bus.operand_a;
                        b     <= bus.operand_b;
                        count <= CW'(W);
                        err_q <= 1'b0;
                        if (bus.cmd) begin
`ifdef ALU_SEQ_DIV_EN
                            if (bus.operand_b == '0) begin
                                res_hi <= bus.operand_a;
                                res_lo <= '1;
                                err_q  <= 1'b1;
                                zero_q <= 1'b0;
                            end
`else
                            res_hi <= '0;
                            res_lo <= '0;
                            err_q  <= 1'b1;
                            zero_q <= 1'b1;
`endif
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc   <= acc_nx;
                    q     <= q_nx;
                    count <= count - CW'(1);
                    if (last) begin
                        res_hi <= acc_nx;
                        res_lo <= q_nx;
                        zero_q <= (acc_nx == '0) && (q_nx == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = (state == S_MUL) || (state == S_DIV);
    assign bus.done        = (state == S_DONE);
    assign bus.err         = err_q;
    assign bus.result_hi   = res_hi;
    assign bus.result_lo   = res_lo;
    assign bus.result_zero = zero_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle arithmetic sequencer that drives the shared combinational ALU to perform unsigned W x W multiply (shift-and-add) and W / W divide (restoring).
- Sits beside the ALU in the datapath and owns the ALU op and operand inputs while busy.
- Computes one bit per clock and returns a 2W-bit result.
- The control unit issues a command with a start pulse and waits for done.

Parameters:
- DATA_BUS_WIDTH, 8, operand width W; must be >= 2 and must match the ALU instance.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  command request; sampled only in IDLE
- cmd  input  1  0 = MUL, 1 = DIV
- operand_a  input  W  multiplicand / dividend
- operand_b  input  W  multiplier / divisor
- busy  output  1  high while a command is executing
- done  output  1  one-cycle pulse when results become valid
- err  output  1  divide-by-zero or unsupported command; valid with done, held until next accept
- result_hi  output  W  MUL: product[2W-1:W]; DIV: remainder
- result_lo  output  W  MUL: product[W-1:0]; DIV: quotient
- result_zero  output  1  {result_hi,result_lo}==0; valid with done
- alu_op  output  alu_op_e  op to ALU
- alu_reg1  output  W  ALU register1
- alu_reg2  output  W  ALU register2
- alu_result  input  W  ALU result
- alu_flag  input  alu_flag_t  ALU flags (alu_carry used; alu_zero ignored)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, err and result_zero = 0; result_hi/lo = 0; count = 0.
- Reset mid-operation aborts the command immediately; no done is produced.
- ALU drive is combinational from state and internal registers.
- In IDLE/DONE: alu_op=NOP and alu_reg1=alu_reg2=0.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE:
  - start=1 is accepted at the clock edge (edge 0): operands are latched, count=W, err=0.
  - cmd=0 -> MUL_RUN with ACC=0, Q=operand_a, B=operand_b.
  - cmd=1 and operand_b!=0 -> DIV_RUN with ACC=0, Q=operand_a, B=operand_b.
  - cmd=1 and operand_b==0 -> DONE directly with result_lo=all ones, result_hi=operand_a, err=1.
- MUL_RUN, per edge:
  - ALU drive: alu_op = Q[0] ? ADD : THR; reg1=ACC; reg2=B.
  - Update: ACC <= {alu_flag.alu_carry, alu_result[W-1:1]}; Q <= {alu_result[0], Q[W-1:1]}; count--.
  - THR carry is 0 by ALU definition.
- DIV_RUN, per edge:
  - Shift: R' = {ACC[W-2:0], Q[W-1]}; m = ACC[W-1].
  - ALU drive: alu_op=SUB, reg1=R', reg2=B.
  - ok = m | ~alu_flag.alu_carry.
  - Update: ACC <= ok ? alu_result : R'; Q <= {Q[W-2:0], ok}; count--.
  - The mod-2^W subtract result is correct when m=1.
- When count==1 in a RUN state: the final step is applied and state becomes DONE.
- DONE:
  - Entered on edge W for RUN commands, or edge 1 for divide-by-zero.
  - Outputs: result_hi=ACC, result_lo=Q, done=1, busy=0; result_zero updated.
  - Next edge returns to IDLE.
  - start asserted during DONE is ignored; the earliest accept is in the following IDLE cycle.
- busy = state is MUL_RUN or DIV_RUN. start while busy is ignored (no queueing).
- Latency: done is high in the cycle following edge W after the accepting edge (W=8: 8 clocks); divide-by-zero takes 1 clock.
- Results and err hold their values from DONE until the next accepted start; done deasserts after one cycle.
- Operands are sampled only at accept; later changes to operand_a/b have no effect.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: DIV is supported as described.
- Undefined: DIV_RUN and the divide logic are not built. cmd=1 goes IDLE->DONE in 1 clock with err=1 and result_hi=result_lo=0; the ALU is never driven with SUB.

Test Plan:
- Reset mid-MUL: start MUL 13*11, assert rst_n=0 at cycle 4 -> busy, done and results drop to 0 at once; no done after release.
- MUL, W=8: start cmd=0, a=13, b=11 -> done exactly 8 clocks after accept, result_hi=0x00, result_lo=0x8F, err=0, result_zero=0. Repeat with a=0xFF, b=0xFF -> hi=0xFE, lo=0x01.
- DIV, W=8: a=200, b=7 -> after 8 clocks lo=0x1C, hi=0x04. a=0xFF, b=0x01 -> lo=0xFF, hi=0x00. a=0x05, b=0x09 -> lo=0x00, hi=0x05.
- Divide by zero: a=0x5A, b=0 -> done 1 clock after accept, lo=0xFF, hi=0x5A, err=1. With ALU_SEQ_DIV_EN undefined, any DIV -> err=1, hi=lo=0.
- Zero and ALU drive: MUL a=0, b=0x80 -> result_zero=1. Check alu_op is never ADD while Q[0]=0, and alu_op=NOP in IDLE/DONE.
- Handshake: pulse start every cycle during busy -> exactly one command completes; start during the done cycle is ignored; start held into the following IDLE is accepted.
